// File: rtl/kill_servo.sv
// kill_servo: servo responder for the game FSM kill request.
// Generates a 50 Hz servo PWM. On a request it slews the horn from the
// rest pulse width to the fire width, holds there, slews back, then
// completes a 4-phase req/ack handshake.
//
// Ports:
//   i_clk_25   in   25 MHz pixel-domain clock
//   i_rst_n    in   asynchronous active-low reset
//   i_req      in   kill request (level, 4-phase)
//   o_ack      out  sequence complete, held until i_req drops
//   o_busy     out  sequence in progress (accept up to ack)
//   o_at_fire  out  horn held at fire position
//   o_pwm      out  servo control pulse
module kill_servo #(
  parameter int CNT_W        = 20,
  parameter int PWM_PERIOD   = 500000,
  parameter int REST_PULSE   = 25000,
  parameter int FIRE_PULSE   = 50000,
  parameter int STEP         = 2500,
  parameter int HOLD_PERIODS = 25
) (
  input  logic i_clk_25,
  input  logic i_rst_n,
  input  logic i_req,
  output logic o_ack,
  output logic o_busy,
  output logic o_at_fire,
  output logic o_pwm
);

  localparam int HW = $clog2(HOLD_PERIODS) + 1;
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(PWM_PERIOD - 1);
  localparam logic [CNT_W-1:0] REST     = CNT_W'(REST_PULSE);
  localparam logic [CNT_W-1:0] FIRE     = CNT_W'(FIRE_PULSE);
  // A step wider than the counter can never limit the slew; saturate it.
  localparam logic [CNT_W-1:0] STEP_C   =
    (longint'(STEP) >= (longint'(1) << CNT_W)) ? {CNT_W{1'b1}} : CNT_W'(STEP);
  localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD_PERIODS - 1);

  typedef enum logic [2:0] {S_IDLE, S_OUT, S_HOLD, S_BACK, S_ACK} state_t;

  state_t           state_r, state_nxt;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] pulse_r, pulse_nxt;
  logic [HW-1:0]    hold_r, hold_nxt;
  logic [CNT_W-1:0] slew_fire, slew_rest;
  logic             boundary;

  // Move cur toward tgt by at most STEP_C. The magnitude is formed first
  // so the unsigned subtraction can never wrap or overshoot.
  function automatic logic [CNT_W-1:0] slew(input logic [CNT_W-1:0] cur,
                                            input logic [CNT_W-1:0] tgt);
    logic [CNT_W-1:0] diff;
    diff = (tgt > cur) ? (tgt - cur) : (cur - tgt);
    if (diff > STEP_C) diff = STEP_C;
    return (tgt > cur) ? (cur + diff) : (cur - diff);
  endfunction

  assign boundary  = (cnt_r == PER_LAST);
  assign slew_fire = slew(pulse_r, FIRE);
  assign slew_rest = slew(pulse_r, REST);

  always_comb begin
    state_nxt = state_r;
    pulse_nxt = pulse_r;
    hold_nxt  = hold_r;
    case (state_r)
      S_IDLE: if (i_req) state_nxt = S_OUT;
      S_OUT: if (boundary) begin
        pulse_nxt = slew_fire;
        if (slew_fire == FIRE) begin
          state_nxt = S_HOLD;
          hold_nxt  = '0;
        end
      end
      S_HOLD: if (boundary) begin
        // The last held period ends on this edge, so the return slew
        // starts here; fire width lasts exactly HOLD_PERIODS periods.
        if (hold_r == HOLD_LAST) begin
          state_nxt = S_BACK;
          pulse_nxt = slew_rest;
        end else begin
          hold_nxt = hold_r + HW'(1);
        end
      end
      S_BACK: if (boundary) begin
        pulse_nxt = slew_rest;
        if (slew_rest == REST) state_nxt = S_ACK;
      end
      S_ACK: if (!i_req) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk_25 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r   <= S_IDLE;
      cnt_r     <= '0;
      pulse_r   <= REST;
      hold_r    <= '0;
      o_pwm     <= 1'b0;
      o_ack     <= 1'b0;
      o_busy    <= 1'b0;
      o_at_fire <= 1'b0;
    end else begin
      state_r   <= state_nxt;
      cnt_r     <= boundary ? '0 : cnt_r + CNT_W'(1);
      pulse_r   <= pulse_nxt;
      hold_r    <= hold_nxt;
      o_pwm     <= (cnt_r < pulse_r);
      // Decoding the next state keeps the flags aligned with state_r
      // while still coming straight from flops.
      o_ack     <= (state_nxt == S_ACK);
      o_busy    <= (state_nxt == S_OUT) || (state_nxt == S_HOLD) ||
                   (state_nxt == S_BACK);
      o_at_fire <= (state_nxt == S_HOLD);
    end
  end

endmodule

// File: tb/tb_kill_servo.sv
// Bench for kill_servo: two instances share clock, reset and request.
// dut_a runs the forward profile (rest 10 -> fire 20), dut_b the reverse
// one (rest 30 -> fire 21). A timeline model predicts every output on
// every cycle plus the high time of every PWM period.
module tb_kill_servo;
  localparam int P = 100, STEP = 4, HOLD = 2, MAXP = 400;
  int rest_p [2] = '{10, 30};
  int fire_p [2] = '{20, 21};

  logic clk = 1'b0, rst_n = 1'b0, req = 1'b0;
  logic [1:0] ack, busy, at_fire, pwm;

  always #5 clk = ~clk;

  kill_servo #(.CNT_W(7), .PWM_PERIOD(P), .REST_PULSE(10), .FIRE_PULSE(20),
               .STEP(STEP), .HOLD_PERIODS(HOLD)) dut_a (
    .i_clk_25(clk), .i_rst_n(rst_n), .i_req(req), .o_ack(ack[0]),
    .o_busy(busy[0]), .o_at_fire(at_fire[0]), .o_pwm(pwm[0]));

  kill_servo #(.CNT_W(20), .PWM_PERIOD(P), .REST_PULSE(30), .FIRE_PULSE(21),
               .STEP(STEP), .HOLD_PERIODS(HOLD)) dut_b (
    .i_clk_25(clk), .i_rst_n(rst_n), .i_req(req), .o_ack(ack[1]),
    .o_busy(busy[1]), .o_at_fire(at_fire[1]), .o_pwm(pwm[1]));

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---- reference model: timeline of one sequence per instance ----
  int e;                       // clock edges since reset release
  bit in_seq [2];              // accepted and not yet back to idle
  int ack_e [2], fs_e [2], fe_e [2];
  int pw [2][MAXP];            // expected width of each PWM period
  int hi [2];                  // measured high cycles in current period

  function automatic int slew(int v, int t);
    if (t > v) return v + (((t - v) < STEP) ? (t - v) : STEP);
    return v - (((v - t) < STEP) ? (v - t) : STEP);
  endfunction

  // Widths of the periods following the first boundary after accept.
  task automatic accept(input int i);
    int prof[$];
    int v, nout, b1;
    v = rest_p[i];
    do begin v = slew(v, fire_p[i]); prof.push_back(v); end while (v != fire_p[i]);
    nout = prof.size();
    repeat (HOLD - 1) prof.push_back(fire_p[i]);
    v = slew(v, rest_p[i]);
    prof.push_back(v);
    do begin v = slew(v, rest_p[i]); prof.push_back(v); end while (v != rest_p[i]);
    b1 = (e / P + 1) * P;
    for (int j = 0; j < prof.size(); j++)
      if (b1 / P + j < MAXP) pw[i][b1 / P + j] = prof[j];
    fs_e[i]  = b1 + (nout - 1) * P;
    fe_e[i]  = fs_e[i] + HOLD * P;
    ack_e[i] = b1 + (prof.size() - 1) * P;
    in_seq[i] = 1'b1;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e = 0;
      for (int i = 0; i < 2; i++) begin
        in_seq[i] = 1'b0;
        hi[i] = 0;
        for (int k = 0; k < MAXP; k++) pw[i][k] = rest_p[i];
      end
    end else begin
      e++;
      for (int i = 0; i < 2; i++) begin
        if (!in_seq[i]) begin
          if (req) accept(i);
        end else if (e > ack_e[i] && !req) begin
          in_seq[i] = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      bit eb, ea, ef, ep;
      eb = 1'b0; ea = 1'b0; ef = 1'b0; ep = 1'b0;
      if (rst_n && e > 0 && e <= MAXP * P) begin
        eb = in_seq[i] && e < ack_e[i];
        ea = in_seq[i] && e >= ack_e[i];
        ef = in_seq[i] && e >= fs_e[i] && e < fe_e[i];
        ep = ((e - 1) % P) < pw[i][(e - 1) / P];
      end
      chk($sformatf("busy%0d@%0d", i, e), busy[i], eb);
      chk($sformatf("ack%0d@%0d", i, e), ack[i], ea);
      chk($sformatf("at_fire%0d@%0d", i, e), at_fire[i], ef);
      chk($sformatf("pwm%0d@%0d", i, e), pwm[i], ep);
      if (rst_n && e > 0 && e <= MAXP * P) begin
        hi[i] += int'(pwm[i]);
        if (e % P == 0) begin
          chk($sformatf("width%0d_period%0d", i, e / P - 1), hi[i], pw[i][e / P - 1]);
          hi[i] = 0;
        end
      end
    end
  end

  // ---- stimulus ----
  task automatic wait_high(input string tag, input int which);
    int n = 0;
    while (((which == 0) ? ack[0] : at_fire[0]) !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, (which == 0) ? ack[0] : at_fire[0], 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_outputs", {ack, busy, at_fire, pwm}, 0);
    rst_n = 1'b1;

    // idle PWM only
    repeat (300) @(negedge clk);

    // request raised mid-period, held until ack, dropped 5 cycles later
    while (e % P != 50) @(negedge clk);
    req = 1'b1;
    @(negedge clk);
    chk("busy_on_accept", busy[0], 1);
    wait_high("ack_rise", 0);
    repeat (5) @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    chk("ack_fall", ack[0], 0);
    repeat (20) @(negedge clk);

    // single-cycle request pulse: full sequence, one-cycle ack
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    wait_high("pulse_ack_rise", 0);
    @(negedge clk);
    chk("pulse_ack_one_cycle", ack[0], 0);
    repeat (50) @(negedge clk);

    // async reset while holding at fire, inside the high part of the pulse
    req = 1'b1;
    wait_high("reach_hold", 1);
    repeat (15) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_outputs", {ack, busy, at_fire, pwm}, 0);
    req = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (250) @(negedge clk);

    // random request levels and durations
    for (int s = 0; s < 40; s++) begin
      req = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 500)) @(negedge clk);
    end
    req = 1'b0;
    repeat (1000) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/kill_servo.md
Name: kill_servo

Overview:
- Servo responder for the game FSM's S_KILL state.
- The game FSM raises a kill request. This block generates a 50 Hz servo PWM, slews the horn from rest to fire position, holds it there, slews back, then acknowledges with a 4-phase req/ack handshake.
- Runs on the 25 MHz pixel-domain clock, next to the game FSM in Top; o_pwm drives a GPIO pin.

Parameters:
- CNT_W, 20, width of the period counter and pulse registers.
- PWM_PERIOD, 500000, PWM period in clock cycles (20 ms at 25 MHz).
- REST_PULSE, 25000, high-time in cycles at rest position (1 ms).
- FIRE_PULSE, 50000, high-time in cycles at fire position (2 ms); may be less than REST_PULSE.
- STEP, 2500, maximum pulse-width change per PWM period (slew limit).
- HOLD_PERIODS, 25, number of PWM periods held at FIRE_PULSE.
- Legal ranges: 1 <= STEP; 1 <= HOLD_PERIODS; REST_PULSE, FIRE_PULSE < PWM_PERIOD <= 2^CNT_W.

Ports:
- i_clk_25  in  1  25 MHz clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_req  in  1  kill request from game FSM (level, 4-phase).
- o_ack  out  1  sequence complete; held until i_req low.
- o_busy  out  1  high from sequence accept until the ack state is entered.
- o_at_fire  out  1  high while in S_HOLD.
- o_pwm  out  1  servo control pulse.

Behaviour:
- Reset (async, i_rst_n low):
  - state = S_IDLE, period counter cnt_r = 0, pulse_r = REST_PULSE.
  - o_pwm, o_ack, o_busy, o_at_fire all 0.
  - Reset mid-sequence aborts immediately; the servo returns to rest via the reset pulse value, with no slew.
- PWM generation:
  - cnt_r counts 0..PWM_PERIOD-1, then wraps to 0, continuously in every state.
  - o_pwm is registered: o_pwm <= (cnt_r < pulse_r). It is high exactly pulse_r cycles per period, one cycle behind cnt_r.
- Boundary cycle: cnt_r == PWM_PERIOD-1.
  - pulse_r changes only on the edge ending a boundary cycle, so each period has a single consistent width.
  - Slew-driven state transitions happen on that same edge.
- Slew toward target T: pulse_r <= pulse_r ± min(STEP, |T - pulse_r|). It never overshoots. Arithmetic is unsigned CNT_W-bit; the difference is computed before subtracting, so there is no underflow.
- States:
  - S_IDLE: o_busy = 0. If i_req = 1 on any cycle, go to S_OUT next edge; o_busy goes to 1 the same edge.
  - S_OUT: at each boundary, slew toward FIRE_PULSE. On the boundary where the updated value equals FIRE_PULSE, go to S_HOLD and clear hold_cnt.
  - S_HOLD: o_at_fire = 1. At each boundary hold_cnt++. On the boundary where hold_cnt == HOLD_PERIODS-1, go to S_BACK.
  - S_BACK: at each boundary, slew toward REST_PULSE. On the boundary where the updated value equals REST_PULSE, go to S_ACK.
  - S_ACK: o_ack = 1, o_busy = 0. When i_req = 0, go to S_IDLE next edge; o_ack drops that edge.
- Request timing:
  - A request accepted mid-period begins moving at the next boundary, so start latency is up to PWM_PERIOD cycles.
  - If REST_PULSE == FIRE_PULSE, S_OUT and S_BACK each last exactly one boundary.
- i_req dropped before S_ACK: the sequence is not cancelled. The servo still completes OUT/HOLD/BACK. S_ACK then sees i_req = 0, so o_ack pulses high for exactly one cycle.
- i_req re-asserted while in S_ACK with ack still high: ignored until the handshake completes. A new request is accepted only in S_IDLE.
- Outputs o_ack, o_busy, o_at_fire are registered, decoded from state_r; no combinational path from i_req.

Test Plan:
All scenarios use PWM_PERIOD = 100, REST_PULSE = 10, FIRE_PULSE = 20, STEP = 4, HOLD_PERIODS = 2.
1. Reset, i_req = 0 for 300 cycles -> o_pwm high exactly 10 of every 100 cycles; o_busy = o_ack = o_at_fire = 0.
2. i_req raised at cnt_r = 50, held until ack -> o_busy next edge; widths 10 then 14, 18, 20, 20, 16, 12, 10. o_at_fire spans the two 20-wide periods; o_ack rises the edge after the boundary that sets 10.
3. Ack handshake from scenario 2: drop i_req 5 cycles after o_ack rises -> o_ack falls the next edge; state S_IDLE; a new i_req is accepted afterwards.
4. i_req pulsed 1 cycle in S_IDLE -> full sequence runs with identical widths to scenario 2; o_ack high exactly 1 cycle.
5. Assert i_rst_n = 0 asynchronously during S_HOLD (width 20) -> all outputs 0 immediately. After release, widths are 10 and state is S_IDLE.
6. Reverse direction, REST_PULSE = 30, FIRE_PULSE = 21, STEP = 4 -> widths 26, 22, 21 (hold ×2), then 25, 29, 30, no overshoot, then ack.
